group_sub_seq: RTL and testbench
================================

GROUP_SUB_SEQ -- requirements
Module: group_sub_seq

Interface
REQ-001 SHALL provide parameter NGRP, default 8, meaning the number of 4-bit groups; operand width W = 4*NGRP (32 by default).
REQ-002 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL provide port start, input, 1, a request to begin a subtraction; sampled only when ready=1.
REQ-005 SHALL provide port a, input, W, the minuend; captured on the accepting edge.
REQ-006 SHALL provide port b, input, W, the subtrahend; captured on the accepting edge.
REQ-007 SHALL provide port ready, output, 1, high when the block is idle and can accept start.
REQ-008 SHALL provide port done, output, 1, a one-cycle pulse marking a valid result.
REQ-009 SHALL provide port diff, output, W, the result a-b modulo 2^W.
REQ-010 SHALL provide port borrow, output, 1, high when a<b (unsigned).
REQ-011 SHALL provide port ovf, output, 1, the two's-complement signed-overflow flag.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE; ready=1 only in IDLE.
REQ-013 SHALL, in IDLE with start=1 at an edge, capture a and ~b, set the internal carry to 1, clear the group counter to 0, and enter RUN.
REQ-014 SHALL, in IDLE with start=0, remain in IDLE and hold diff, borrow and ovf unchanged.
REQ-015 SHALL, in RUN, process exactly one 4-bit group per cycle, group k = bits [4k+3:4k], starting at k=0 (LSB group first).
REQ-016 SHALL form each group result in carry-select fashion:
- compute a 4-bit ripple sum of a_k + ~b_k with carry-in 0;
- derive the +1 version with a binary-to-excess-1 converter;
- select sum and carry-out by the current carry.
REQ-017 SHALL write the selected 4-bit sum into diff[4k+3:4k] and register the selected carry-out as the carry for group k+1.
REQ-018 SHALL, when the group counter equals NGRP-1, process that group and enter DONE at the same edge.
REQ-019 SHALL, on entering DONE, set borrow = NOT(final carry-out) and set ovf = (a[W-1] != b[W-1]) AND (diff[W-1] != a[W-1]), using the captured operands.
REQ-020 SHALL assert done=1 for exactly the one cycle spent in DONE, then return to IDLE at the next edge.
REQ-021 SHALL raise done NGRP cycles after the accepting edge; the earliest following accept occurs NGRP+2 edges after the previous one.
REQ-022 SHALL ignore start, a and b while in RUN or DONE; captured operands SHALL NOT change.
REQ-023 SHALL hold diff, borrow and ovf stable from the DONE cycle until the next accepting edge.
REQ-024 SHALL treat start held continuously high as a new request each time IDLE is entered, with no lost or duplicated operation.
REQ-025 SHALL keep the group counter width ceil(log2(NGRP)) or wider, with no wrap-around inside one operation.

Reset
REQ-026 SHALL, on rst_n low (asynchronously, including mid-RUN), force:
- state IDLE, ready=1, done=0;
- diff=0, borrow=0, ovf=0;
- carry=0 and counter=0.
REQ-027 SHALL discard any in-progress operation on reset and produce no done pulse for it.
REQ-028 SHALL, after rst_n deasserts, accept start at the first rising edge.

Verification
REQ-029 Bench SHALL check a=0x00000007, b=0x00000001 -> diff=0x00000006, borrow=0, ovf=0, done exactly 8 cycles after accept.
REQ-030 Bench SHALL check a=0x00000000, b=0x00000001 -> diff=0xFFFFFFFF, borrow=1, ovf=0 (full borrow ripple through all 8 groups).
REQ-031 Bench SHALL check a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, borrow=0, ovf=1; and a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, borrow=1, ovf=1.
REQ-032 Bench SHALL check a=b=0xFFFFFFFF -> diff=0x00000000, borrow=0, ovf=0; with start held high throughout, the second accept occurs 10 edges after the first.
REQ-033 Bench SHALL check that start with a=0x12345678 pulsed during RUN of a=0x10, b=0x3 is ignored: result diff=0x0000000D, one done pulse only.
REQ-034 Bench SHALL check that rst_n pulsed low for 1 ns at cycle 4 of RUN immediately yields ready=1, done=0, diff=0, and that no done pulse follows.

Source files
------------

// File: rtl/group_sub_seq_if.sv
// Handshake and operand/result bundle for the group-serial subtractor.
interface group_sub_seq_if #(
    parameter int unsigned NGRP = 8
);
    localparam int unsigned W = 4 * NGRP;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;

    modport master (
        output start, a, b,
        input  ready, done, diff, borrow, ovf
    );

    modport slave (
        input  start, a, b,
        output ready, done, diff, borrow, ovf
    );
endinterface

// File: rtl/group_sub_seq.sv
// Sequential a-b: one 4-bit carry-select group per cycle, LSB group first.
// Subtraction is a + ~b + 1, the +1 entering as the initial carry.
module group_sub_seq #(
    parameter int unsigned NGRP = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    group_sub_seq_if.slave bus
);
    localparam int unsigned W  = 4 * NGRP;
    localparam int unsigned CW = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [CW-1:0] LAST = CW'(NGRP - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  bn_q, bn_d;
    logic [W-1:0]  diff_q, diff_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic          borrow_q, borrow_d;
    logic          ovf_q, ovf_d;

    logic [3:0] grp_a, grp_b;
    logic [3:0] sum0, sum1, grp_sum;
    logic [4:0] rc;
    logic       cout0, cout1, grp_cout;

    assign grp_a = a_q[{cnt_q, 2'b00} +: 4];
    assign grp_b = bn_q[{cnt_q, 2'b00} +: 4];

    // Ripple sum with carry-in 0, then excess-1 conversion for the carry-in 1 path.
    always_comb begin
        rc    = '0;
        sum0  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            sum0[i]  = grp_a[i] ^ grp_b[i] ^ rc[i];
            rc[i+1]  = (grp_a[i] & grp_b[i]) | (rc[i] & (grp_a[i] ^ grp_b[i]));
        end
        cout0   = rc[4];
        sum1[0] = ~sum0[0];
        sum1[1] = sum0[1] ^ sum0[0];
        sum1[2] = sum0[2] ^ (sum0[1] & sum0[0]);
        sum1[3] = sum0[3] ^ (sum0[2] & sum0[1] & sum0[0]);
        cout1   = cout0 | (&sum0);
        grp_sum  = carry_q ? sum1  : sum0;
        grp_cout = carry_q ? cout1 : cout0;
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        bn_d     = bn_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    bn_d    = ~bus.b;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d[{cnt_q, 2'b00} +: 4] = grp_sum;
                carry_d = grp_cout;
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    borrow_d = ~grp_cout;
                    // Top group's sum bit is the result MSB; b's MSB is the inverse of the stored ~b.
                    ovf_d    = (a_q[W-1] != ~bn_q[W-1]) && (grp_sum[3] != a_q[W-1]);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            bn_q     <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            bn_q     <= bn_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.ready  = (state_q == IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_group_sub_seq.sv
// Randomized and directed bench for group_sub_seq against an arithmetic reference.
module tb_group_sub_seq;
    localparam int unsigned NGRP = 8;
    localparam int unsigned W    = 4 * NGRP;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;

    group_sub_seq_if #(.NGRP(NGRP)) bus ();

    group_sub_seq #(.NGRP(NGRP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.done) done_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain modular, unsigned and signed arithmetic.
    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] av, input logic [W-1:0] bv);
        return av - bv;
    endfunction

    function automatic logic ref_borrow(input logic [W-1:0] av, input logic [W-1:0] bv);
        return av < bv;
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] av, input logic [W-1:0] bv);
        longint sd;
        sd = longint'($signed(av)) - longint'($signed(bv));
        return (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    endfunction

    task automatic wait_ready();
        int t = 0;
        while (!bus.ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("ready_wait", 64'(bus.ready), 64'd1);
    endtask

    // One operation; while busy, optionally throws random start/a/b at the block.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit garbage);
        int n = 0;
        int dc0;
        logic [W-1:0] ed;
        wait_ready();
        ed        = ref_diff(av, bv);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk); #1;
        dc0       = done_cnt;
        bus.start = 1'b0;
        check("busy_after_accept", 64'(bus.ready), 64'd0);
        while (!bus.done && n < 40) begin
            if (garbage) begin
                bus.start = 1'($urandom);
                bus.a     = $urandom;
                bus.b     = $urandom;
            end
            @(posedge clk); #1;
            n++;
        end
        bus.start = 1'b0;
        check("latency", 64'(n), 64'(NGRP));
        check("diff", 64'(bus.diff), 64'(ed));
        check("borrow", 64'(bus.borrow), 64'(ref_borrow(av, bv)));
        check("ovf", 64'(bus.ovf), 64'(ref_ovf(av, bv)));
        @(posedge clk); #1;
        check("done_width", 64'(bus.done), 64'd0);
        check("ready_back", 64'(bus.ready), 64'd1);
        check("done_count", 64'(done_cnt - dc0), 64'd1);
        @(posedge clk); #1;
        check("diff_hold", 64'(bus.diff), 64'(ed));
        check("borrow_hold", 64'(bus.borrow), 64'(ref_borrow(av, bv)));
    endtask

    initial begin
        int acc[$];
        int dc0;
        logic [W-1:0] ra, rb;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #12;
        check("rst_ready", 64'(bus.ready), 64'd1);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_diff", 64'(bus.diff), 64'd0);
        check("rst_borrow", 64'(bus.borrow), 64'd0);
        check("rst_ovf", 64'(bus.ovf), 64'd0);
        rst_n = 1'b1;

        // Directed boundary cases; first one is accepted at the first edge after reset.
        run_op(32'h0000_0007, 32'h0000_0001, 1'b0);
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        // Start pulsed with other operands during RUN must be ignored.
        wait_ready();
        bus.start = 1'b1;
        bus.a     = 32'h10;
        bus.b     = 32'h3;
        @(posedge clk); #1;
        dc0       = done_cnt;
        bus.start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        bus.start = 1'b1;
        bus.a     = 32'h1234_5678;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        check("ignore_diff", 64'(bus.diff), 64'h0000_000D);
        check("ignore_done_count", 64'(done_cnt - dc0), 64'd1);
        check("ignore_ready", 64'(bus.ready), 64'd1);

        // Start held high: back-to-back accepts every NGRP+2 edges.
        bus.start = 1'b1;
        bus.a     = '1;
        bus.b     = '1;
        for (int c = 0; c < 40 && acc.size() < 2; c++) begin
            if (bus.done) check("held_diff", 64'(bus.diff), 64'd0);
            if (bus.ready) acc.push_back(c);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        check("held_accepts", 64'(acc.size()), 64'd2);
        if (acc.size() == 2) check("held_spacing", 64'(acc[1] - acc[0]), 64'(NGRP + 2));
        wait_ready();

        // Asynchronous reset at RUN cycle 4 aborts the operation silently.
        bus.start = 1'b1;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'h0000_1111;
        @(posedge clk); #1;
        bus.start = 1'b0;
        dc0       = done_cnt;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", 64'(bus.ready), 64'd1);
        check("arst_done", 64'(bus.done), 64'd0);
        check("arst_diff", 64'(bus.diff), 64'd0);
        check("arst_borrow", 64'(bus.borrow), 64'd0);
        check("arst_ovf", 64'(bus.ovf), 64'd0);
        rst_n = 1'b1;
        repeat (15) begin @(posedge clk); #1; end
        check("arst_no_done", 64'(done_cnt - dc0), 64'd0);

        // Randomized operands with random noise on the inputs while busy.
        for (int i = 0; i < 25; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 1) rb = ra;
            if (i % 5 == 2) rb = ra + 1;
            run_op(ra, rb, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
